// File: rtl/e203_exu_mt_oitf.sv
// rtl/e203_exu_mt_oitf.sv - multithread-aware outstanding instruction track FIFO
//
// Tracks long-pipe instructions from dispatch to write-back. Each dispatch
// allocates one entry and receives its index as the itag. The head entry
// drives the long-pipe write-back stage, and the whole table is searched for
// register hazards against the dispatching instruction of the same thread.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   dis_ena / dis_ready       allocate request / not full
//   dis_ptr                   itag the next allocation receives
//   disp_i_*                  dispatching instruction: payload and sources
//   oitfrd_match_dis*         hazard flags for rs1/rs2/rs3/rd
//   oitf_ret_ena              pop the head entry
//   oitf_ret_ptr, oitf_ret_*  head index and head payload
//   oitf_empty, oitf_full     occupancy status
module e203_exu_mt_oitf #(
  parameter int DEPTH       = 2,
  parameter int ITAG_WIDTH  = 1,
  parameter int THREADS_NUM = 2,
  parameter int RFIDX_WIDTH = 5,
  parameter int PC_SIZE     = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dis_ena,
  output logic                   dis_ready,
  output logic [ITAG_WIDTH-1:0]  dis_ptr,
  input  logic [THREADS_NUM-1:0] disp_i_thread_sel,
  input  logic [RFIDX_WIDTH-1:0] disp_i_rdidx,
  input  logic                   disp_i_rdwen,
  input  logic                   disp_i_rdfpu,
  input  logic [PC_SIZE-1:0]     disp_i_pc,
  input  logic [RFIDX_WIDTH-1:0] disp_i_rs1idx,
  input  logic [RFIDX_WIDTH-1:0] disp_i_rs2idx,
  input  logic [RFIDX_WIDTH-1:0] disp_i_rs3idx,
  input  logic                   disp_i_rs1en,
  input  logic                   disp_i_rs2en,
  input  logic                   disp_i_rs3en,
  input  logic                   disp_i_rs1fpu,
  input  logic                   disp_i_rs2fpu,
  input  logic                   disp_i_rs3fpu,
  output logic                   oitfrd_match_disrs1,
  output logic                   oitfrd_match_disrs2,
  output logic                   oitfrd_match_disrs3,
  output logic                   oitfrd_match_disrd,
  input  logic                   oitf_ret_ena,
  output logic [ITAG_WIDTH-1:0]  oitf_ret_ptr,
  output logic [RFIDX_WIDTH-1:0] oitf_ret_rdidx,
  output logic [PC_SIZE-1:0]     oitf_ret_pc,
  output logic                   oitf_ret_rdwen,
  output logic                   oitf_ret_rdfpu,
  output logic [THREADS_NUM-1:0] oitf_ret_thread_sel,
  output logic                   oitf_empty,
  output logic                   oitf_full
);

  // Pointers carry the wrap flag in the MSB; index in the low bits.
  logic [ITAG_WIDTH:0] wptr;
  logic [ITAG_WIDTH:0] rptr;

  logic [DEPTH-1:0]       valid;
  logic [RFIDX_WIDTH-1:0] rdidx_r  [DEPTH];
  logic [PC_SIZE-1:0]     pc_r     [DEPTH];
  logic                   rdwen_r  [DEPTH];
  logic                   rdfpu_r  [DEPTH];
  logic [THREADS_NUM-1:0] thread_r [DEPTH];

  logic alloc;
  logic ret;

  function automatic logic [ITAG_WIDTH:0] ptr_next(input logic [ITAG_WIDTH:0] p);
    if (p[ITAG_WIDTH-1:0] == ITAG_WIDTH'(DEPTH - 1))
      return {~p[ITAG_WIDTH], {ITAG_WIDTH{1'b0}}};
    else
      return {p[ITAG_WIDTH], p[ITAG_WIDTH-1:0] + ITAG_WIDTH'(1)};
  endfunction

  assign oitf_empty = (wptr[ITAG_WIDTH-1:0] == rptr[ITAG_WIDTH-1:0]) & (wptr[ITAG_WIDTH] == rptr[ITAG_WIDTH]);
  assign oitf_full  = (wptr[ITAG_WIDTH-1:0] == rptr[ITAG_WIDTH-1:0]) & (wptr[ITAG_WIDTH] != rptr[ITAG_WIDTH]);
  // Depends on registered state only, so a same-cycle pop cannot open a slot.
  assign dis_ready  = ~oitf_full;
  assign alloc      = dis_ena & dis_ready;
  assign ret        = oitf_ret_ena & ~oitf_empty;

  assign dis_ptr      = wptr[ITAG_WIDTH-1:0];
  assign oitf_ret_ptr = rptr[ITAG_WIDTH-1:0];

  assign oitf_ret_rdidx      = rdidx_r[rptr[ITAG_WIDTH-1:0]];
  assign oitf_ret_pc         = pc_r[rptr[ITAG_WIDTH-1:0]];
  assign oitf_ret_rdwen      = rdwen_r[rptr[ITAG_WIDTH-1:0]];
  assign oitf_ret_rdfpu      = rdfpu_r[rptr[ITAG_WIDTH-1:0]];
  assign oitf_ret_thread_sel = thread_r[rptr[ITAG_WIDTH-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rdidx_r[i]  <= '0;
        pc_r[i]     <= '0;
        rdwen_r[i]  <= 1'b0;
        rdfpu_r[i]  <= 1'b0;
        thread_r[i] <= '0;
      end
    end else begin
      // alloc and ret can only hit the same index when full or empty,
      // and one of them is blocked in both of those cases.
      if (ret) begin
        valid[rptr[ITAG_WIDTH-1:0]] <= 1'b0;
        rptr <= ptr_next(rptr);
      end
      if (alloc) begin
        valid[wptr[ITAG_WIDTH-1:0]]    <= 1'b1;
        rdidx_r[wptr[ITAG_WIDTH-1:0]]  <= disp_i_rdidx;
        pc_r[wptr[ITAG_WIDTH-1:0]]     <= disp_i_pc;
        rdwen_r[wptr[ITAG_WIDTH-1:0]]  <= disp_i_rdwen;
        rdfpu_r[wptr[ITAG_WIDTH-1:0]]  <= disp_i_rdfpu;
        thread_r[wptr[ITAG_WIDTH-1:0]] <= disp_i_thread_sel;
        wptr <= ptr_next(wptr);
      end
    end
  end

  // Hazard search over registered entries only; same-thread writers matter.
  always_comb begin
    oitfrd_match_disrs1 = 1'b0;
    oitfrd_match_disrs2 = 1'b0;
    oitfrd_match_disrs3 = 1'b0;
    oitfrd_match_disrd  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && rdwen_r[i] && (thread_r[i] == disp_i_thread_sel)) begin
        if (disp_i_rs1en && (rdidx_r[i] == disp_i_rs1idx) && (rdfpu_r[i] == disp_i_rs1fpu))
          oitfrd_match_disrs1 = 1'b1;
        if (disp_i_rs2en && (rdidx_r[i] == disp_i_rs2idx) && (rdfpu_r[i] == disp_i_rs2fpu))
          oitfrd_match_disrs2 = 1'b1;
        if (disp_i_rs3en && (rdidx_r[i] == disp_i_rs3idx) && (rdfpu_r[i] == disp_i_rs3fpu))
          oitfrd_match_disrs3 = 1'b1;
        if (disp_i_rdwen && (rdidx_r[i] == disp_i_rdidx) && (rdfpu_r[i] == disp_i_rdfpu))
          oitfrd_match_disrd = 1'b1;
      end
    end
  end

endmodule

// File: doc/e203_exu_mt_oitf.md
# e203_exu_mt_oitf

Multithread-aware Outstanding Instruction Track FIFO (OITF) feeding the long-pipe write-back stage. It allocates one entry per long-pipe instruction at dispatch and hands back an itag. Its head entry supplies the destination register, PC, write-enable, FPU flag and thread of the oldest outstanding instruction to `e203_exu_longpwbck`, and it pops the head on that block's `oitf_ret_ena`. It also flags register hazards between dispatching instructions and outstanding entries of the same thread.

## Interface
Parameters:
- `DEPTH`, 2: entry count; power of two, ≥2.
- `ITAG_WIDTH`, 1: log2(`DEPTH`); equals `E203_ITAG_WIDTH`.
- `THREADS_NUM`, 2: equals `E203_THREADS_NUM`; thread selects are one-hot.
- `RFIDX_WIDTH`, 5; `PC_SIZE`, 32.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `dis_ena` in 1: allocate an entry this cycle (qualified internally by `dis_ready`).
- `dis_ready` out 1: `~oitf_full`.
- `dis_ptr` out ITAG_WIDTH: itag the next allocation receives (= write pointer index).
- `disp_i_thread_sel` in THREADS_NUM: thread of the dispatching instruction.
- `disp_i_rdidx` in RFIDX_WIDTH, `disp_i_rdwen` in 1, `disp_i_rdfpu` in 1, `disp_i_pc` in PC_SIZE: payload stored in the allocated entry.
- `disp_i_rs1idx`/`rs2idx`/`rs3idx` in RFIDX_WIDTH, `disp_i_rs1en`/`rs2en`/`rs3en` in 1, `disp_i_rs1fpu`/`rs2fpu`/`rs3fpu` in 1: source operands for hazard check.
- `oitfrd_match_disrs1`/`rs2`/`rs3`/`rd` out 1: hazard flags.
- `oitf_ret_ena` in 1: pop the head entry.
- `oitf_ret_ptr` out ITAG_WIDTH: head index (read pointer).
- `oitf_ret_rdidx`, `oitf_ret_pc`, `oitf_ret_rdwen`, `oitf_ret_rdfpu`, `oitf_ret_thread_sel`: head entry payload.
- `oitf_empty` out 1, `oitf_full` out 1.

## Operation
- **Pointers.** Write and read pointers are each ITAG_WIDTH bits plus one wrap flag.
  - Alloc (`dis_ena & dis_ready`): write entry[wptr], set valid[wptr], then increment. On wrap from DEPTH-1 to 0, toggle the wrap flag.
  - Ret (`oitf_ret_ena & ~oitf_empty`): clear valid[rptr], then increment the read pointer with the same wrap rule.
- **Status.**
  - `oitf_empty` = (ptr equal) & (flag equal).
  - `oitf_full` = (ptr equal) & (flag differ).
- **Head outputs.** All `oitf_ret_*` fields are combinational reads of entry[rptr]. Their value is don't-care when empty, but they must never be X after reset.
- **Hazard match.** For each source x, OR over all entries i of:
  - valid[i]
  - & rdwen[i]
  - & (thread_sel[i] == `disp_i_thread_sel`)
  - & (rdidx[i] == `disp_i_rsxidx`)
  - & (rdfpu[i] == `disp_i_rsxfpu`)
  - & `disp_i_rsxen`

  The `rd` flag uses `disp_i_rdidx`/`rdfpu`/`rdwen` in the same way. Entries from other threads never match.
- **Match timing.** Flags reflect registered state only. An entry allocated or retired in the same cycle does not change that cycle's flags.
- **Invalid handshakes.**
  - `oitf_ret_ena` while empty is ignored; no state change.
  - `dis_ena` while full is ignored.

## Timing
- **Reset** (asynchronous, applied immediately on `rst`): pointers and flags 0, valid all 0, payload registers 0. Resulting outputs:
  - `oitf_empty`=1, `oitf_full`=0, `dis_ready`=1.
  - `dis_ptr`=0, `oitf_ret_ptr`=0.
  - All `oitf_ret_*` = 0 and all match flags = 0.
- **Alloc latency.** Entry visible one cycle after alloc: `oitf_empty` falls and the match flags see it on the next cycle.
- **Ret latency.** Pop takes effect at the edge; the next head is presented the following cycle.
- **Alloc and ret in the same cycle** (not empty, not full): both pointers advance and occupancy is unchanged. If the entry is the same one (single-entry case), the valid clear and the new-entry set act on different indices, so there is no conflict.
- **Full.** When full, `dis_ready`=0 even if `oitf_ret_ena`=1 in the same cycle; the freed slot becomes available next cycle. There is no combinational path from `oitf_ret_ena` to `dis_ready`.
- **Empty.** When empty, `dis_ena`=1 and `oitf_ret_ena`=1 result in alloc only.
- **Reset mid-operation.** All outstanding entries are discarded; next cycle matches reset state.

## Test plan
- **Reset.** Assert `rst` with DEPTH=2 after 1 alloc -> `oitf_empty`=1, `dis_ptr`=0, `oitf_ret_ptr`=0, all match flags 0, within the same cycle (async).
- **Fill and drain.**
  - Alloc rd=5, pc=0x100, then rd=7, pc=0x104 -> `oitf_full`=1, `dis_ready`=0.
  - Head shows rdidx=5, pc=0x100. Ret -> head rdidx=7, pc=0x104. Ret -> `oitf_empty`=1.
- **Wrap-around.** 5 alloc/ret pairs, one at a time -> `dis_ptr` sequence 0,1,0,1,0. `oitf_ret_ptr` follows one cycle behind each alloc, and empty/full stay correct across wraps.
- **Simultaneous alloc and ret.**
  - With 1 entry, alloc+ret same cycle -> occupancy stays 1 and the head becomes the new entry.
  - When full, alloc+ret -> only ret takes effect; `dis_ready` goes 1 next cycle.
- **Hazard and thread isolation.** Outstanding entry thread 2'b01, rd=3, rdwen=1.
  - Dispatch thread 2'b01, rs1=3, rs1en=1 -> `oitfrd_match_disrs1`=1.
  - Same with thread 2'b10 -> 0.
  - rs1fpu=1 -> 0.
  - rs1en=0 -> 0.
- **Illegal handshakes.** `oitf_ret_ena`=1 while empty -> no pointer change. `dis_ena`=1 while full -> entry[0] payload unchanged.
